// File: rtl/dcache_pkg.sv
// Shared types and line/word byte-mapping helpers for the direct-mapped data cache.
// A line stores byte k at bits [127-8k : 120-8k]; CPU words are little-endian inside.
package dcache_pkg;

   localparam int LINE_BYTES  = 16;
   localparam int OFFSET_BITS = 4;

   typedef logic [127:0] line_t;

   typedef enum logic [1:0] {
      IDLE,
      WRITEBACK,
      REFILL
   } state_t;

   function automatic logic [31:0] word_from_line(line_t line, logic [1:0] w);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 4; i++) begin
         r[8*i +: 8] = line[127 - 8*(4*int'(w) + i) -: 8];
      end
      return r;
   endfunction

   function automatic line_t line_merge_word(line_t line, logic [1:0] w,
                                             logic [31:0] data, logic [3:0] byte_en);
      line_t r;
      r = line;
      for (int i = 0; i < 4; i++) begin
         if (byte_en[i]) r[127 - 8*(4*int'(w) + i) -: 8] = data[8*i +: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/dcache_if.sv
// CPU access path and line-memory bus of the data cache, bundled as one interface.
// master = cache controller view, slave = CPU + data memory view.
interface dcache_if;
   import dcache_pkg::*;

   logic        cpu_req;
   logic        cpu_we;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [3:0]  cpu_byte_en;
   logic [31:0] cpu_rdata;
   logic        cpu_stall;

   logic        mem_req;
   logic        WriteEnable;
   logic [31:0] memory_address;
   line_t       mem_writedata;
   line_t       mem_readdata;
   logic        mem_ready;

   modport master (
      input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_byte_en,
      output cpu_rdata, cpu_stall,
      output mem_req, WriteEnable, memory_address, mem_writedata,
      input  mem_readdata, mem_ready
   );

   modport slave (
      output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_byte_en,
      input  cpu_rdata, cpu_stall,
      input  mem_req, WriteEnable, memory_address, mem_writedata,
      output mem_readdata, mem_ready
   );

endinterface

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage: combinational read, synchronous CPU-write and refill ports.
// Reset clears only valid and dirty; tag and data contents survive.
module dcache_array
   import dcache_pkg::*;
#(
   parameter int NUM_LINES  = 16,
   parameter int INDEX_BITS = 4,
   parameter int TAG_BITS   = 24
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [INDEX_BITS-1:0] rd_idx,
   output logic                  rd_valid,
   output logic                  rd_dirty,
   output logic [TAG_BITS-1:0]   rd_tag,
   output line_t                 rd_line,
   input  logic                  wr_en,
   input  line_t                 wr_line,
   input  logic                  fill_en,
   input  logic [INDEX_BITS-1:0] fill_idx,
   input  logic [TAG_BITS-1:0]   fill_tag,
   input  line_t                 fill_line
);

   logic [NUM_LINES-1:0] valid;
   logic [NUM_LINES-1:0] dirty;
   logic [TAG_BITS-1:0]  tags [NUM_LINES];
   line_t                data [NUM_LINES];

   assign rd_valid = valid[rd_idx];
   assign rd_dirty = dirty[rd_idx];
   assign rd_tag   = tags[rd_idx];
   assign rd_line  = data[rd_idx];

   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= '0;
         dirty <= '0;
      end else begin
         if (fill_en) begin
            valid[fill_idx] <= 1'b1;
            dirty[fill_idx] <= 1'b0;
         end
         if (wr_en) dirty[rd_idx] <= 1'b1;
      end
   end

   // The controller never raises fill_en and wr_en together (different FSM states).
   always_ff @(posedge clk) begin
      if (fill_en) begin
         data[fill_idx] <= fill_line;
         tags[fill_idx] <= fill_tag;
      end else if (wr_en) begin
         data[rd_idx] <= wr_line;
      end
   end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back, write-allocate data cache controller.
// Combinational lookup in IDLE; misses sequence an optional dirty writeback then a refill.
module dcache_controller
   import dcache_pkg::*;
#(
   parameter int NUM_LINES = 16
) (
   input  logic     clk,
   input  logic     rst,
   dcache_if.master bus
);

   localparam int INDEX_BITS = $clog2(NUM_LINES);
   localparam int TAG_BITS   = 32 - OFFSET_BITS - INDEX_BITS;

   state_t      state;
   logic        we_q;
   logic [31:0] addr_q;
   logic [31:0] refill_addr;

   logic [INDEX_BITS-1:0] idx;
   logic [TAG_BITS-1:0]   tag;
   logic [1:0]            wsel;
   logic                  rd_valid, rd_dirty, hit;
   logic [TAG_BITS-1:0]   rd_tag;
   line_t                 rd_line;
   logic                  wr_en, fill_en;
   logic                  unused_addr_bits;

   assign idx  = bus.cpu_addr[OFFSET_BITS +: INDEX_BITS];
   assign tag  = bus.cpu_addr[31 -: TAG_BITS];
   assign wsel = bus.cpu_addr[3:2];
   assign unused_addr_bits = ^bus.cpu_addr[1:0];

   assign hit = rd_valid && (rd_tag == tag);

   assign wr_en   = (state == IDLE) && bus.cpu_req && bus.cpu_we && hit && !rst;
   assign fill_en = (state == REFILL) && bus.mem_ready && !rst;

   dcache_array #(
      .NUM_LINES (NUM_LINES),
      .INDEX_BITS(INDEX_BITS),
      .TAG_BITS  (TAG_BITS)
   ) u_array (
      .clk      (clk),
      .rst      (rst),
      .rd_idx   (idx),
      .rd_valid (rd_valid),
      .rd_dirty (rd_dirty),
      .rd_tag   (rd_tag),
      .rd_line  (rd_line),
      .wr_en    (wr_en),
      .wr_line  (line_merge_word(rd_line, wsel, bus.cpu_wdata, bus.cpu_byte_en)),
      .fill_en  (fill_en),
      .fill_idx (refill_addr[OFFSET_BITS +: INDEX_BITS]),
      .fill_tag (refill_addr[31 -: TAG_BITS]),
      .fill_line(bus.mem_readdata)
   );

   // Request drops in the ready cycle, and immediately under reset.
   assign bus.mem_req        = (state != IDLE) && !bus.mem_ready && !rst;
   assign bus.WriteEnable    = we_q;
   assign bus.memory_address = addr_q;
   assign bus.mem_writedata  = (state == WRITEBACK) ? rd_line : '0;
   assign bus.cpu_stall      = (state != IDLE) || (bus.cpu_req && !hit);
   assign bus.cpu_rdata      = ((state == IDLE) && bus.cpu_req && hit)
                               ? word_from_line(rd_line, wsel) : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         we_q        <= 1'b0;
         addr_q      <= '0;
         refill_addr <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.cpu_req && !hit) begin
                  refill_addr <= {bus.cpu_addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                  if (rd_valid && rd_dirty) begin
                     state  <= WRITEBACK;
                     we_q   <= 1'b1;
                     addr_q <= {rd_tag, idx, {OFFSET_BITS{1'b0}}};
                  end else begin
                     state  <= REFILL;
                     we_q   <= 1'b0;
                     addr_q <= {bus.cpu_addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
                  end
               end
            end
            WRITEBACK: begin
               if (bus.mem_ready) begin
                  state  <= REFILL;
                  we_q   <= 1'b0;
                  addr_q <= refill_addr;
               end
            end
            REFILL: begin
               if (bus.mem_ready) begin
                  state  <= IDLE;
                  addr_q <= '0;
               end
            end
            default: begin
               state  <= IDLE;
               we_q   <= 1'b0;
               addr_q <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dcache_controller.sv
// Directed bench for dcache_controller with a behavioural line memory and
// scoreboards for expected load data and expected memory transactions.
module tb_dcache_controller;
   import dcache_pkg::*;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      line_t       wdata;
   } txn_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;
   logic inject_ready;

   line_t       mem [logic [31:0]];
   txn_t        exp_mem [$];
   logic [31:0] exp_rd [$];

   dcache_if bus ();

   dcache_controller #(.NUM_LINES(16)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic line_t dflt_line(logic [31:0] a);
      return {a ^ 32'hA5A5_0000, ~a, a + 32'h1111_1111, a ^ 32'h0F0F_0F0F};
   endfunction

   function automatic line_t mem_rd(logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return dflt_line(a);
   endfunction

   function automatic logic [31:0] tb_word(line_t l, int w);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 4; i++) r[8*i +: 8] = l[127 - 8*(4*w + i) -: 8];
      return r;
   endfunction

   task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   function automatic txn_t mk(logic we, logic [31:0] a, line_t d);
      txn_t t;
      t.we = we; t.addr = a; t.wdata = d;
      return t;
   endfunction

   // Line memory: samples mem_req mid-cycle, answers with a one-cycle ready pulse.
   initial begin
      logic        p;
      logic        pwe;
      logic [31:0] pa;
      line_t       pwd;
      txn_t        e;
      bus.mem_ready    = 1'b0;
      bus.mem_readdata = '0;
      forever begin
         @(negedge clk);
         if (bus.mem_req === 1'b1) begin
            chk("req_during_ready", {127'b0, bus.mem_ready}, 128'd0);
            chk("req_addr_aligned", {124'b0, bus.memory_address[3:0]}, 128'd0);
         end
         p   = (bus.mem_req === 1'b1);
         pwe = bus.WriteEnable;
         pa  = bus.memory_address;
         pwd = bus.mem_writedata;
         @(posedge clk);
         #1;
         if (p) begin
            checks++;
            assert (exp_mem.size() != 0) else begin
               errors++;
               $error("FAIL unexpected_mem: observed we=%0b addr=%0h expected no transaction", pwe, pa);
            end
            if (exp_mem.size() != 0) begin
               e = exp_mem.pop_front();
               chk("mem_we", {127'b0, pwe}, {127'b0, e.we});
               chk("mem_addr", {96'b0, pa}, {96'b0, e.addr});
               if (e.we) chk("mem_wdata", pwd, e.wdata);
            end
            if (pwe) mem[pa] = pwd;
            bus.mem_readdata = pwe ? '0 : mem_rd(pa);
         end
         bus.mem_ready = p || inject_ready;
         inject_ready  = 1'b0;
      end
   end

   // Called just after a rising edge; returns just after the edge ending the access.
   task automatic access(input string name, input logic we, input logic [31:0] a,
                         input logic [31:0] wd, input logic [3:0] be,
                         input logic [31:0] exp_data, input int exp_stall);
      int          st;
      logic        done;
      logic [31:0] e;
      if (!we) exp_rd.push_back(exp_data);
      bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a;
      bus.cpu_wdata = wd; bus.cpu_byte_en = be;
      st = 0; done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (!bus.cpu_stall) begin
            done = 1'b1;
            if (!we) begin
               e = exp_rd.pop_front();
               chk({name, "_rdata"}, {96'b0, bus.cpu_rdata}, {96'b0, e});
            end
         end else begin
            st++;
         end
         @(posedge clk);
         #1;
      end
      bus.cpu_req = 1'b0;
      chk({name, "_done"}, {127'b0, done}, 128'd1);
      chk({name, "_stall"}, 128'(st), 128'(exp_stall));
      chk({name, "_mem_left"}, 128'(exp_mem.size()), 128'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      line_t line1, line1w, line4;
      checks = 0; errors = 0; inject_ready = 1'b0;
      rst = 1'b1;
      bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0;
      bus.cpu_wdata = '0; bus.cpu_byte_en = '0;
      for (int k = 0; k < 16; k++) line1[127 - 8*k -: 8] = (k < 15) ? 8'((k + 1) * 8'h11) : 8'h00;
      mem[32'h0001_0000] = line1;

      // Reset, then a stale ready pulse in the first IDLE cycle.
      repeat (2) @(posedge clk);
      @(negedge clk);
      inject_ready = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("rst_mem_req", {127'b0, bus.mem_req}, 128'd0);
      chk("rst_stall", {127'b0, bus.cpu_stall}, 128'd0);
      chk("rst_we", {127'b0, bus.WriteEnable}, 128'd0);
      chk("rst_addr", {96'b0, bus.memory_address}, 128'd0);
      chk("rst_rdata", {96'b0, bus.cpu_rdata}, 128'd0);
      @(posedge clk); #1;

      // 1: clean load miss, then re-load hit.
      exp_mem.push_back(mk(1'b0, 32'h0001_0000, '0));
      access("t1_miss", 1'b0, 32'h0001_0004, '0, 4'h0, 32'h8877_6655, 3);
      access("t1_hit", 1'b0, 32'h0001_0004, '0, 4'h0, 32'h8877_6655, 0);

      // 2: store hit on byte 0, then load it back.
      access("t2_store", 1'b1, 32'h0001_0000, 32'h0000_00AA, 4'b0001, '0, 0);
      access("t2_load", 1'b0, 32'h0001_0000, '0, 4'h0, 32'h4433_22AA, 0);

      // 3: conflicting load evicts the dirty line.
      line1w = line1;
      line1w[127:120] = 8'hAA;
      exp_mem.push_back(mk(1'b1, 32'h0001_0000, line1w));
      exp_mem.push_back(mk(1'b0, 32'h0001_0100, '0));
      access("t3_dirty", 1'b0, 32'h0001_0100, '0, 4'h0, tb_word(dflt_line(32'h0001_0100), 0), 5);
      chk("t3_mem_byte0", {120'b0, mem[32'h0001_0000][127:120]}, 128'hAA);

      // 4: store miss allocates clean line (no writeback), written on retry.
      exp_mem.push_back(mk(1'b0, 32'h0001_0200, '0));
      access("t4_store", 1'b1, 32'h0001_0208, 32'h1234_5678, 4'b1111, '0, 3);
      access("t4_load", 1'b0, 32'h0001_0208, '0, 4'h0, 32'h1234_5678, 0);
      line4 = dflt_line(32'h0001_0200);
      line4[63:56] = 8'h78; line4[55:48] = 8'h56; line4[47:40] = 8'h34; line4[39:32] = 8'h12;
      exp_mem.push_back(mk(1'b1, 32'h0001_0200, line4));
      exp_mem.push_back(mk(1'b0, 32'h0001_0300, '0));
      access("t4_evict", 1'b0, 32'h0001_0300, '0, 4'h0, tb_word(dflt_line(32'h0001_0300), 0), 5);
      chk("t4_mem_byte8", {120'b0, mem[32'h0001_0200][63:56]}, 128'h78);

      // 5: reset in the refill ready cycle abandons the fill.
      exp_mem.push_back(mk(1'b0, 32'h0002_0040, '0));
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h0002_0040;
      @(negedge clk);
      chk("t5_miss_stall", {127'b0, bus.cpu_stall}, 128'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("t5_req", {127'b0, bus.mem_req}, 128'd1);
      chk("t5_req_addr", {96'b0, bus.memory_address}, {96'b0, 32'h0002_0040});
      chk("t5_req_we", {127'b0, bus.WriteEnable}, 128'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chk("t5_rst_req", {127'b0, bus.mem_req}, 128'd0);
      inject_ready = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; bus.cpu_req = 1'b0;
      @(negedge clk);
      chk("t5_post_req", {127'b0, bus.mem_req}, 128'd0);
      chk("t5_post_stall", {127'b0, bus.cpu_stall}, 128'd0);
      chk("t5_post_addr", {96'b0, bus.memory_address}, 128'd0);
      chk("t5_post_mem_left", 128'(exp_mem.size()), 128'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("t5_idle_req", {127'b0, bus.mem_req}, 128'd0);
      @(posedge clk); #1;
      exp_mem.push_back(mk(1'b0, 32'h0002_0040, '0));
      access("t5_reload", 1'b0, 32'h0002_0040, '0, 4'h0, tb_word(dflt_line(32'h0002_0040), 0), 3);
      // Line 0 was invalidated by the reset as well.
      exp_mem.push_back(mk(1'b0, 32'h0001_0300, '0));
      access("t5_inval", 1'b0, 32'h0001_0304, '0, 4'h0, tb_word(dflt_line(32'h0001_0300), 1), 3);

      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
- Direct-mapped, write-back, write-allocate data cache between the CPU load/store path and the 128-bit line-based data memory.
- CPU side: single 32-bit word/byte-enable access per cycle, with a stall output.
- Memory side: line initiator for the data memory's req/ready protocol; ports are named to connect directly to it.
- Owns line refill and dirty-line writeback sequencing.

Parameters:
NUM_LINES, 16, number of cache lines; power of two, >=2; INDEX_BITS = log2(NUM_LINES)
LINE_BYTES, 16, bytes per line; fixed, not overridable; OFFSET_BITS = 4, TAG_BITS = 28 - INDEX_BITS

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
cpu_req  input  1  CPU access valid this cycle
cpu_we  input  1  1 = store, 0 = load
cpu_addr  input  32  byte address; bits [1:0] ignored (word access)
cpu_wdata  input  32  store data, little-endian lanes
cpu_byte_en  input  4  byte_en[i] writes cpu_wdata[8i+7:8i]
cpu_rdata  output  32  load data, valid when cpu_req && !cpu_stall
cpu_stall  output  1  CPU must hold request and retry
mem_req  output  1  line transaction request
WriteEnable  output  1  1 = writeback, 0 = refill
memory_address  output  32  line-aligned address, bits [3:0] = 0
mem_writedata  output  128  line being written back
mem_readdata  input  128  refill line, valid in the mem_ready cycle
mem_ready  input  1  one-cycle completion pulse, one cycle after a sampled mem_req

Behaviour:
- Line layout, used on both sides: line byte k occupies bits [127-8k : 120-8k].
- CPU word at word offset w maps cpu_rdata[8i+7:8i] = line byte 4w+i.
  - Example: line bytes 11 22 33 44 give word 0x44332211.
- Lookup is combinational in IDLE. hit = valid[idx] && tag[idx] == cpu_addr[31:4+INDEX_BITS].
- FSM states: IDLE, WRITEBACK, REFILL.
  - IDLE:
    - Load hit: cpu_rdata driven same cycle, cpu_stall = 0.
    - Store hit: enabled bytes written and dirty set at the clock edge, cpu_stall = 0.
    - Miss with cpu_req: cpu_stall = 1. Next state is WRITEBACK if the victim is valid && dirty, else REFILL.
    - Captured at the miss edge: victim address {victim tag, idx, 4'b0}, refill address {cpu_addr[31:4], 4'b0}.
  - WRITEBACK: WriteEnable = 1, memory_address = victim address, mem_writedata = victim line. On mem_ready, go to REFILL.
  - REFILL: WriteEnable = 0, memory_address = refill address. On mem_ready, install mem_readdata, set valid, clear dirty, store the tag, go to IDLE.
- mem_req = (state is WRITEBACK or REFILL) && !mem_ready. The request drops in the ready cycle so memory never sees a duplicate request.
- cpu_stall = 1 in WRITEBACK and REFILL. In IDLE, cpu_stall = cpu_req && !hit.
- The retried access hits in IDLE the cycle after install.
  - Clean miss: stall in cycles C, C+1, C+2; data or write in C+3.
  - Dirty miss: stall in C..C+4; completes in C+5.
- A store miss allocates (refill first), then performs the hit write on retry. Memory is not written until eviction.
- mem_ready is ignored in IDLE, including a stale pulse after reset.
- cpu_rdata = 0 when not hitting. WriteEnable = 0 and memory_address = 0 in IDLE.
- Reset, including mid-WRITEBACK or mid-REFILL:
  - State goes to IDLE; all valid and dirty bits clear; the in-flight transaction is abandoned.
  - mem_req = 0 from the reset cycle onward.
  - Data and tag arrays are not cleared.
- cpu_byte_en = 0 store: hit is treated normally; no bytes change, but dirty is set.
- CPU inputs change while stalled: undefined. The CPU holds them stable.

Decomposition:
- Package dcache_pkg: LINE_BYTES, OFFSET_BITS, line_t (logic [127:0]), state enum {IDLE, WRITEBACK, REFILL}.
- Package functions: word_from_line(line, w) and line_merge_word(line, w, data, byte_en), which implement the byte mapping above.
- Sub-module dcache_array:
  - Tag, valid, dirty and data storage with combinational read.
  - Synchronous write ports for the CPU write, refill install and reset clear.
- The controller FSM and address mux stay in the top level.

Test Plan:
1. Reset; memory bytes 0x10000..0x1000F = 11 22 .. 00 (incrementing 0x11 steps); load 0x00010004:
   - Stall 3 cycles; exactly one refill at 0x00010000 with WriteEnable = 0.
   - cpu_rdata = 0x88776655. An immediate re-load hits with no mem_req.
2. After 1, store 0x000000AA byte_en 0001 to 0x00010000:
   - No stall, no mem traffic.
   - Load 0x00010000 returns 0x443322AA.
3. After 2, load 0x00010100 (same index, NUM_LINES = 16):
   - Writeback at 0x00010000 with mem_writedata[127:120] = 0xAA, then refill at 0x00010100.
   - Stall 5 cycles.
4. Store miss 0x12345678 byte_en 1111 to 0x00010208:
   - Refill of 0x00010200 only; no WriteEnable = 1 transaction.
   - Load returns 0x12345678. Line byte 8 = 0x78.
5. Assert rst during the REFILL cycle:
   - mem_req = 0 next cycle; stale mem_ready ignored.
   - A load of the same address misses and refills again.
6. Protocol assertion across all tests: mem_req never stays high in a cycle where mem_ready = 1; memory_address[3:0] == 0 whenever mem_req is high.
